// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction timer: FSM state encoding and
// Fibonacci LFSR tap masks (bit k set means tap k+1 is fed back).
package reaction_pkg;

  typedef enum logic [2:0] {IDLE, ARM, WAIT, TIMING, DONE} state_t;

  localparam logic [12:0] LFSR13_TAPS = 13'h1C80;  // taps 13,12,11,8

  function automatic logic [31:0] lfsr_taps(input int w);
    case (w)
      2:       lfsr_taps = 32'h3;
      3:       lfsr_taps = 32'h6;
      4:       lfsr_taps = 32'hC;
      5:       lfsr_taps = 32'h14;
      6:       lfsr_taps = 32'h30;
      7:       lfsr_taps = 32'h60;
      8:       lfsr_taps = 32'hB8;
      9:       lfsr_taps = 32'h110;
      10:      lfsr_taps = 32'h240;
      11:      lfsr_taps = 32'h500;
      12:      lfsr_taps = 32'h829;
      13:      lfsr_taps = 32'(LFSR13_TAPS);
      14:      lfsr_taps = 32'h2015;
      15:      lfsr_taps = 32'h6000;
      16:      lfsr_taps = 32'hD008;
      default: lfsr_taps = 32'h3 << (w - 2);
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running clock divider: one-cycle tick every CLK_HZ/TICK_HZ clocks.
module tick_gen #(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 1000
) (
  input  logic Board_clk,
  input  logic Reset,
  output logic tick
);
  localparam int DIV = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [DW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == DW'(DIV - 1));
  assign tick   = w_wrap;

  always_ff @(posedge Board_clk or posedge Reset) begin
    if (Reset)       r_cnt <= '0;
    else if (w_wrap) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end
endmodule

// File: rtl/reaction_timer_core.sv
// N-player reaction timer: start-light sequencing, random hold-off, reaction
// timing with false-start/timeout detection and best-time tracking.
module reaction_timer_core
  import reaction_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int TICK_HZ    = 1000,
  parameter int CNT_W      = 12,
  parameter int N_PLAYERS  = 1,
  parameter int LED_W      = 10,
  parameter int STEP_TICKS = 500,
  parameter int LFSR_W     = 13,
  parameter int MIN_DELAY  = 1000,
  localparam int WIN_W     = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
  input  logic                 Board_clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [N_PLAYERS-1:0] Stop,
  output logic [LED_W-1:0]     LED,
  output logic [CNT_W-1:0]     time_ms,
  output logic [WIN_W-1:0]     winner,
  output logic                 result_valid,
  output logic                 false_start,
  output logic                 timeout,
  output logic [CNT_W-1:0]     best_ms,
  output logic                 busy
);
  localparam int STEP_W  = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam int DLY_MAX = MIN_DELAY + (1 << (LFSR_W - 1)) - 1;
  localparam int DLY_W   = (DLY_MAX > 1) ? $clog2(DLY_MAX + 1) : 1;
  localparam logic [LFSR_W-1:0] TAPS    = LFSR_W'(lfsr_taps(LFSR_W));
  localparam logic [CNT_W-1:0]  CNT_MAX = '1;

  logic w_tick;
  tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
    .Board_clk(Board_clk), .Reset(Reset), .tick(w_tick)
  );

  logic [LFSR_W-1:0]    r_lfsr;
  logic [1:0]           r_start_s;
  logic                 r_start_d;
  logic [N_PLAYERS-1:0] r_stop_s1, r_stop_s2, r_stop_d;

  always_ff @(posedge Board_clk or posedge Reset) begin
    if (Reset) begin
      r_lfsr    <= LFSR_W'(1);
      r_start_s <= '0;
      r_start_d <= 1'b0;
      r_stop_s1 <= '0;
      r_stop_s2 <= '0;
      r_stop_d  <= '0;
    end else begin
      r_lfsr    <= {r_lfsr[LFSR_W-2:0], ^(r_lfsr & TAPS)};
      r_start_s <= {r_start_s[0], Start};
      r_start_d <= r_start_s[1];
      r_stop_s1 <= Stop;
      r_stop_s2 <= r_stop_s1;
      r_stop_d  <= r_stop_s2;
    end
  end

  logic                 w_start_edge, w_any_stop;
  logic [N_PLAYERS-1:0] w_stop_edge;
  logic [WIN_W-1:0]     w_win;
  logic [CNT_W-1:0]     r_cnt, w_cnt_inc;
  logic [LED_W-1:0]     r_led, w_led_shift;

  assign w_start_edge = r_start_s[1] & ~r_start_d;
  assign w_stop_edge  = r_stop_s2 & ~r_stop_d;
  assign w_any_stop   = |w_stop_edge;
  // A press landing on the saturating tick still counts, with the saturated value.
  assign w_cnt_inc    = (w_tick && r_cnt != CNT_MAX) ? r_cnt + 1'b1 : r_cnt;
  assign w_led_shift  = LED_W'({r_led, 1'b1});

  always_comb begin
    w_win = '0;
    for (int i = N_PLAYERS - 1; i >= 0; i--)
      if (w_stop_edge[i]) w_win = WIN_W'(i);
  end

  state_t           r_state;
  logic [STEP_W-1:0] r_step;
  logic [DLY_W-1:0]  r_delay;
  logic [CNT_W-1:0]  r_time, r_best;
  logic [WIN_W-1:0]  r_winner;
  logic              r_valid, r_fs, r_to, r_busy;

  always_ff @(posedge Board_clk or posedge Reset) begin
    if (Reset) begin
      r_state  <= IDLE;
      r_led    <= '0;
      r_step   <= '0;
      r_delay  <= '0;
      r_cnt    <= '0;
      r_time   <= '0;
      r_best   <= '1;
      r_winner <= '0;
      r_valid  <= 1'b0;
      r_fs     <= 1'b0;
      r_to     <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE, DONE: if (w_start_edge) begin
          r_state <= ARM;
          r_busy  <= 1'b1;
          r_fs    <= 1'b0;
          r_to    <= 1'b0;
          r_led   <= '0;
          r_step  <= '0;
        end
        ARM, WAIT: if (w_any_stop) begin
          r_fs     <= 1'b1;
          r_winner <= w_win;
          r_time   <= '0;
          r_led    <= '1;
          r_state  <= DONE;
          r_valid  <= 1'b1;
          r_busy   <= 1'b0;
        end else if (w_tick) begin
          if (r_state == WAIT) begin
            if (r_delay <= DLY_W'(1)) begin
              r_led   <= '0;
              r_cnt   <= '0;
              r_state <= TIMING;
            end else r_delay <= r_delay - 1'b1;
          end else if (r_step == STEP_W'(STEP_TICKS - 1)) begin
            r_step <= '0;
            r_led  <= w_led_shift;
            if (&w_led_shift) begin
              r_delay <= DLY_W'(MIN_DELAY) + DLY_W'(r_lfsr[LFSR_W-2:0]);
              r_state <= WAIT;
            end
          end else r_step <= r_step + 1'b1;
        end
        TIMING: if (w_any_stop) begin
          r_time   <= w_cnt_inc;
          r_winner <= w_win;
          if (r_best > w_cnt_inc) r_best <= w_cnt_inc;
          r_state  <= DONE;
          r_valid  <= 1'b1;
          r_busy   <= 1'b0;
        end else if (w_tick) begin
          r_cnt <= w_cnt_inc;
          if (w_cnt_inc == CNT_MAX) begin
            r_time   <= '1;
            r_to     <= 1'b1;
            r_winner <= '0;
            r_state  <= DONE;
            r_valid  <= 1'b1;
            r_busy   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign LED          = r_led;
  assign time_ms      = r_time;
  assign winner       = r_winner;
  assign result_valid = r_valid;
  assign false_start  = r_fs;
  assign timeout      = r_to;
  assign best_ms      = r_best;
  assign busy         = r_busy;
endmodule

// File: tb/tb_reaction_timer_core.sv
// Bench for reaction_timer_core: directed round table, false-start and reset
// sequences, then random rounds scored by a tick-arithmetic model.
module tb_reaction_timer_core;
  localparam int TPC  = 10;  // clocks per tick: 10 kHz / 1 kHz
  localparam int MAXT = 63;  // saturated 6-bit reaction count

  logic       clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [1:0] stop = 2'b00;
  logic [3:0] led;
  logic [5:0] time_ms, best_ms;
  logic [0:0] winner;
  logic       rv, fs, to, busy;
  int         checks = 0, failures = 0;
  int         model_best;

  reaction_timer_core #(
    .CLK_HZ(10000), .TICK_HZ(1000), .CNT_W(6), .N_PLAYERS(2), .LED_W(4),
    .STEP_TICKS(2), .LFSR_W(4), .MIN_DELAY(5)
  ) dut (
    .Board_clk(clk), .Reset(rst), .Start(start), .Stop(stop), .LED(led),
    .time_ms(time_ms), .winner(winner), .result_valid(rv), .false_start(fs),
    .timeout(to), .best_ms(best_ms), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         c;      // clocks after LED->0 before Stop is driven
    logic [1:0] mask;   // 0 = no press
    bit         poke;   // pulse Start during TIMING
    int         t, w;
    bit         tmo;
    int         best;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_led(input logic [3:0] v, input string name);
    int n;
    n = 0;
    while (led !== v && n < 2000) begin @(negedge clk); n++; end
    chk({name, " led reached"}, led === v, 1);
  endtask

  task automatic start_round;
    @(negedge clk); start = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic await_result(input string name);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!rv && n < 1000);
    chk({name, " result_valid"}, rv, 1);
  endtask

  task automatic check_done(input string name, input int t, input int w, input bit f,
                            input bit tm, input logic [3:0] l, input int b);
    chk({name, " time_ms"}, time_ms, t);
    chk({name, " winner"}, winner, w);
    chk({name, " false_start"}, fs, f);
    chk({name, " timeout"}, to, tm);
    chk({name, " led"}, led, l);
    chk({name, " best_ms"}, best_ms, b);
    chk({name, " busy"}, busy, 0);
    @(negedge clk);
    chk({name, " pulse width"}, rv, 0);
  endtask

  task automatic play(input int c, input logic [1:0] mask, input bit poke, input int t,
                      input int w, input bit tm, input int b, input string name);
    int n;
    start_round;
    wait_led(4'hF, name);
    chk({name, " busy"}, busy, 1);
    n = 0;
    while (led !== 4'h0 && n < 500) begin @(negedge clk); n++; end
    chk({name, " holdoff"}, (n % TPC == 0) && (n / TPC >= 5) && (n / TPC <= 12), 1);
    if (poke) start = 1'b1;
    if (mask != 2'b00) begin
      for (int i = 0; i < c; i++) begin
        @(negedge clk);
        if (i == 3) start = 1'b0;
      end
      stop = mask;
    end
    start = 1'b0;
    await_result(name);
    check_done(name, t, w, 1'b0, tm, 4'h0, b);
    stop = 2'b00;
  endtask

  task automatic false_round(input logic [3:0] at_led, input int dly, input logic [1:0] mask,
                             input string name);
    start_round;
    wait_led(at_led, name);
    repeat (dly) @(negedge clk);
    stop = mask;
    await_result(name);
    check_done(name, 0, mask[0] ? 0 : 1, 1'b1, 1'b0, 4'hF, model_best);
    stop = 2'b00;
  endtask

  initial begin
    vec_t       tbl[7];
    int         seen, kind, c, t;
    logic [1:0] m;
    tbl[0] = '{367, 2'b10, 1'b0, 37, 1, 1'b0, 37};
    tbl[1] = '{497, 2'b10, 1'b1, 50, 1, 1'b0, 37};
    tbl[2] = '{197, 2'b10, 1'b0, 20, 1, 1'b0, 20};
    tbl[3] = '{97,  2'b11, 1'b0, 10, 0, 1'b0, 10};
    tbl[4] = '{627, 2'b01, 1'b0, 63, 0, 1'b0, 10};
    tbl[5] = '{0,   2'b00, 1'b0, 63, 0, 1'b1, 10};
    tbl[6] = '{5,   2'b10, 1'b0, 0,  1, 1'b0, 0};

    repeat (3) @(negedge clk);
    chk("reset led", led, 0);
    chk("reset time_ms", time_ms, 0);
    chk("reset winner", winner, 0);
    chk("reset result_valid", rv, 0);
    chk("reset false_start", fs, 0);
    chk("reset timeout", to, 0);
    chk("reset best_ms", best_ms, MAXT);
    chk("reset busy", busy, 0);
    rst = 1'b0;
    model_best = MAXT;
    repeat (5) @(negedge clk);

    for (int k = 0; k < 7; k++) begin
      play(tbl[k].c, tbl[k].mask, tbl[k].poke, tbl[k].t, tbl[k].w, tbl[k].tmo,
           tbl[k].best, $sformatf("vec%0d", k));
      model_best = tbl[k].best;
    end

    false_round(4'b0011, 0, 2'b01, "fs_arm");
    seen = 0;
    stop = 2'b10;
    repeat (8) begin @(negedge clk); if (rv) seen++; end
    stop = 2'b00;
    chk("done ignores stop pulses", seen, 0);
    chk("done ignores stop winner", winner, 0);
    false_round(4'hF, 10, 2'b10, "fs_wait");

    start_round;
    wait_led(4'hF, "rst_mid");
    wait_led(4'h0, "rst_mid");
    repeat (20) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async reset led", led, 0);
    chk("async reset busy", busy, 0);
    chk("async reset best_ms", best_ms, MAXT);
    chk("async reset time_ms", time_ms, 0);
    @(negedge clk);
    rst = 1'b0;
    model_best = MAXT;
    repeat (3) @(negedge clk);

    for (int r = 0; r < 16; r++) begin
      kind = $urandom_range(0, 3);
      m    = 2'($urandom_range(1, 3));
      if (kind == 0) begin
        false_round(4'b0001, $urandom_range(0, 100), m, "rnd_fs");
      end else if (kind == 1) begin
        play(0, 2'b00, 1'b0, MAXT, 0, 1'b1, model_best, "rnd_timeout");
      end else begin
        c = $urandom_range(0, 627);
        t = (c + 3) / TPC;  // press lands 3 clocks later; one count per elapsed tick
        if (t < model_best) model_best = t;
        play(c, m, 1'b0, t, m[0] ? 0 : 1, 1'b0, model_best, "rnd_hit");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
